// File: rtl/fsquare_if.sv
// rtl/fsquare_if.sv - operand/result handshake bundle for the fsquare squarer
//
// Purpose : groups the valid/ready operand channel and the valid/ready result
//           channel of fsquare into one port.
// Signals : in_valid/in_ready/var1/rm  - operand channel (issue side)
//           out_valid/out_ready/res/flags - result channel (writeback side)
// Modports: master - the issuing/consuming agent; slave - the squarer.

interface fsquare_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] var1;
   logic [2:0]  rm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] res;
   logic [3:0]  flags;

   modport master (
      output in_valid, var1, rm, out_ready,
      input  in_ready, out_valid, res, flags
   );

   modport slave (
      input  in_valid, var1, rm, out_ready,
      output in_ready, out_valid, res, flags
   );
endinterface

// File: rtl/fsquare.sv
// rtl/fsquare.sv - multi-cycle IEEE-754 single-precision squarer (var1*var1)
//
// Purpose : squares a single-precision operand with a 24-step shift-add
//           mantissa multiplier, then normalises and rounds per rm.
//           Subnormal inputs are treated as zero; results that underflow
//           are flushed to zero.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset, discards any operation
//           bus  - fsquare_if.slave: operand channel (in_valid/in_ready/
//                  var1/rm) and result channel (out_valid/out_ready/res/
//                  flags = {NV, OF, UF, NX})

module fsquare (
   input  logic     clk,
   input  logic     rst,
   fsquare_if.slave bus
);

   typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  exp_q, exp_d;
   logic [23:0] man_q, man_d;
   logic [2:0]  rm_q, rm_d;
   logic [47:0] prod_q, prod_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] res_q, res_d;
   logic [3:0]  flags_q, flags_d;

   // Rounding datapath, evaluated from the finished product while in ROUND.
   logic signed [9:0] e_base, e_norm, e_fin;
   logic [23:0]       mant;
   logic              guard, sticky, inc, nx;
   logic [24:0]       mant_sum;
   logic [22:0]       frac_fin;
   logic [31:0]       rnd_res;
   logic [3:0]        rnd_flags;

   always_comb begin
      // 2E - 127 stays well inside a signed 10-bit range for E in 1..254.
      e_base = $signed({1'b0, exp_q, 1'b0}) - 10'sd127;
      if (prod_q[47]) begin
         mant   = prod_q[47:24];
         guard  = prod_q[23];
         sticky = |prod_q[22:0];
         e_norm = e_base + 10'sd1;
      end else begin
         mant   = prod_q[46:23];
         guard  = prod_q[22];
         sticky = |prod_q[21:0];
         e_norm = e_base;
      end

      case (rm_q)
         3'b001, 3'b010: inc = 1'b0;                        // RTZ, RDN (sign is +)
         3'b011:         inc = guard | sticky;              // RUP
         3'b100:         inc = guard;                       // RMM
         default:        inc = guard & (sticky | mant[0]);  // RNE and 101..111
      endcase

      nx       = guard | sticky;
      mant_sum = {1'b0, mant} + {24'd0, inc};

      // Carry out of an all-ones mantissa lands on the next binade at 1.0.
      if (mant_sum[24]) begin
         frac_fin = 23'd0;
         e_fin    = e_norm + 10'sd1;
      end else begin
         frac_fin = mant_sum[22:0];
         e_fin    = e_norm;
      end

      if (e_fin >= 10'sd255) begin
         rnd_flags = 4'b0101;
         rnd_res   = (rm_q == 3'b001 || rm_q == 3'b010) ? 32'h7F7FFFFF : 32'h7F800000;
      end else if (e_fin <= 10'sd0) begin
         rnd_flags = 4'b0011;
         rnd_res   = 32'h00000000;
      end else begin
         rnd_flags = {3'b000, nx};
         rnd_res   = {1'b0, e_fin[7:0], frac_fin};
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      man_d   = man_q;
      rm_d    = rm_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      flags_d = flags_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               exp_d  = bus.var1[30:23];
               man_d  = {1'b1, bus.var1[22:0]};
               rm_d   = bus.rm;
               prod_d = 48'd0;
               cnt_d  = 5'd0;
               if (bus.var1[30:23] == 8'hFF) begin
                  state_d = DONE;
                  if (bus.var1[22:0] != 23'd0) begin
                     res_d   = 32'h7FC00000;
                     flags_d = bus.var1[22] ? 4'b0000 : 4'b1000;  // sNaN signals NV
                  end else begin
                     res_d   = 32'h7F800000;
                     flags_d = 4'b0000;
                  end
               end else if (bus.var1[30:23] == 8'h00) begin
                  state_d = DONE;
                  res_d   = 32'h00000000;
                  flags_d = 4'b0000;
               end else begin
                  state_d = MUL;
               end
            end
         end
         MUL: begin
            if (man_q[cnt_q])
               prod_d = prod_q + ({24'd0, man_q} << cnt_q);
            if (cnt_q == 5'd23) begin
               cnt_d   = 5'd0;
               state_d = ROUND;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         ROUND: begin
            res_d   = rnd_res;
            flags_d = rnd_flags;
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         exp_q   <= 8'd0;
         man_q   <= 24'd0;
         rm_q    <= 3'd0;
         prod_q  <= 48'd0;
         cnt_q   <= 5'd0;
         res_q   <= 32'd0;
         flags_q <= 4'd0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         man_q   <= man_d;
         rm_q    <= rm_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         flags_q <= flags_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.res       = res_q;
   assign bus.flags     = flags_q;

endmodule

// File: tb/tb_fsquare.sv
// tb/tb_fsquare.sv - scoreboard testbench for the fsquare squarer

module tb_fsquare;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [35:0] sb[$];   // expected {flags, res}, in issue order

   fsquare_if bus();

   fsquare u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: every consumed result is compared with the oldest expectation.
   initial begin
      logic [35:0] e;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", bus.res, 32'hFFFFFFFF);
            end else begin
               e = sb.pop_front();
               chk("res", bus.res, e[31:0]);
               chk("flags", {28'd0, bus.flags}, {28'd0, e[35:32]});
            end
         end
      end
   end

   // Present an operand, wait (bounded) for acceptance, then count cycles
   // from the acceptance edge to the first cycle with out_valid high.
   task automatic send(input logic [31:0] op, input logic [2:0] m,
                       output int lat, output int waits);
      bus.var1     = op;
      bus.rm       = m;
      bus.in_valid = 1'b1;
      waits = 0;
      @(negedge clk);
      while (!bus.in_ready && waits < 60) begin
         @(negedge clk);
         waits++;
      end
      if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.var1     = 32'hDEADBEEF;   // later changes must not matter
      bus.rm       = 3'b011;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 40);
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      @(posedge clk);
      #1;
      while (!bus.in_ready && w < 60) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (!bus.in_ready) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic issue(input string name, input logic [31:0] op, input logic [2:0] m,
                        input logic [31:0] er, input logic [3:0] ef, input int elat);
      int lat, waits;
      sb.push_back({ef, er});
      send(op, m, lat, waits);
      chk({name, "_latency"}, lat, elat);
      wait_idle();
   endtask

   initial begin
      int lat, waits;
      total = 0;
      bad   = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.var1      = 32'd0;
      bus.rm        = 3'd0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_res", bus.res, 32'd0);
      chk("rst_flags", {28'd0, bus.flags}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      //    name        operand       rm     result        flags    latency
      issue("sq1p5",    32'h3FC00000, 3'b000, 32'h40100000, 4'b0000, 26);
      issue("sqm2",     32'hC0000000, 3'b000, 32'h40800000, 4'b0000, 26);
      issue("ulp_rne",  32'h3F800001, 3'b000, 32'h3F800002, 4'b0001, 26);
      issue("ulp_rup",  32'h3F800001, 3'b011, 32'h3F800003, 4'b0001, 26);
      issue("ulp_rtz",  32'h3F800001, 3'b001, 32'h3F800002, 4'b0001, 26);
      issue("ulp_rmm",  32'h3F800001, 3'b100, 32'h3F800002, 4'b0001, 26);
      issue("max_rne",  32'h3FFFFFFF, 3'b000, 32'h407FFFFE, 4'b0001, 26);
      issue("max_rup",  32'h3FFFFFFF, 3'b011, 32'h407FFFFF, 4'b0001, 26);
      issue("of_rne",   32'h5F800000, 3'b000, 32'h7F800000, 4'b0101, 26);
      issue("of_rtz",   32'h5F800000, 3'b001, 32'h7F7FFFFF, 4'b0101, 26);
      issue("of_rm7",   32'h5F800000, 3'b111, 32'h7F800000, 4'b0101, 26);
      issue("uf_rne",   32'h1F800000, 3'b000, 32'h00000000, 4'b0011, 26);
      issue("snan",     32'h7F800001, 3'b000, 32'h7FC00000, 4'b1000, 1);
      issue("qnan",     32'h7FC00001, 3'b000, 32'h7FC00000, 4'b0000, 1);
      issue("ninf",     32'hFF800000, 3'b000, 32'h7F800000, 4'b0000, 1);
      issue("subn",     32'h00000001, 3'b000, 32'h00000000, 4'b0000, 1);

      // Backpressure: result held for five cycles, then a new operand is
      // offered together with out_ready and must wait one cycle for IDLE.
      bus.out_ready = 1'b0;
      sb.push_back({4'b0000, 32'h40100000});
      send(32'h3FC00000, 3'b000, lat, waits);
      chk("bp_latency", lat, 26);
      for (int i = 0; i < 5; i++) begin
         chk("bp_res", bus.res, 32'h40100000);
         chk("bp_flags", {28'd0, bus.flags}, 32'd0);
         chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      sb.push_back({4'b0000, 32'h40800000});
      send(32'hC0000000, 3'b000, lat, waits);
      chk("bp_accept_wait", waits, 1);
      chk("bp_next_latency", lat, 26);
      wait_idle();

      // Reset in the middle of MUL discards the operation.
      bus.var1     = 32'h3FC00000;
      bus.rm       = 3'b000;
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("pre_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("mid_rst_res", bus.res, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      issue("sq3", 32'h40400000, 3'b000, 32'h41100000, 4'b0000, 26);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
